bin_to_bcd_4: RTL and testbench

BIN_TO_BCD_4 -- requirements
Module: bin_to_bcd_4

---
 rtl/bin_to_bcd_4_pkg.sv | 18 +
 rtl/bin_to_bcd_4_add3.sv | 10 +
 rtl/bin_to_bcd_4.sv | 93 +++++++++
 tb/tb_bin_to_bcd_4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_4_pkg.sv
// Shared constants and FSM encoding for the 4-digit binary-to-BCD converter.
// Widths here set the scratch, counter and saturation limits used by the converter.
package bin_to_bcd_4_pkg;

  localparam int BCD_DIGITS  = 4;
  localparam int BIN_W       = 16;
  localparam int MAX_BCD_VAL = 9999;
  localparam int ITER_CNT    = 16;
  localparam int CNT_W       = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bin_to_bcd_4_add3.sv
// Double-dabble digit correction: in >= 5 ? in + 3 : in, purely combinational.
// Arithmetic stays 4-bit; inputs above 12 only occur for saturated values.
module bcd_add3 (
  input  logic [3:0] iNib,
  output logic [3:0] oNib
);

  assign oNib = (iNib >= 4'd5) ? iNib + 4'd3 : iNib;

endmodule

// File: rtl/bin_to_bcd_4.sv
// Sequential double-dabble: 16-bit binary to 4 BCD digits, result 16 cycles after accept.
// No backpressure: iSTART is ignored while busy; values above 9999 saturate to OVF_CODE.
module bin_to_bcd_4
  import bin_to_bcd_4_pkg::*;
#(
  parameter logic [4*BCD_DIGITS-1:0] OVF_CODE = 16'h9999
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iSTART,
  input  logic [BIN_W-1:0]        iBIN,
  output logic [4*BCD_DIGITS-1:0] oBCD,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oOVF
);

  state_t                  state;
  state_t                  stateNext;
  logic [BIN_W-1:0]        binReg;
  logic [BIN_W-1:0]        binNext;
  logic [4*BCD_DIGITS-1:0] scratch;
  logic [4*BCD_DIGITS-1:0] scratchAdj;
  logic [4*BCD_DIGITS-1:0] scratchNext;
  logic [CNT_W-1:0]        iterCnt;
  logic                    ovfFlag;
  logic                    accept;
  logic                    lastIter;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : gDigit
    bcd_add3 uAdd3 (
      .iNib(scratch[4*d +: 4]),
      .oNib(scratchAdj[4*d +: 4])
    );
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iSTART) stateNext = CONV;
      CONV:    if (iterCnt == CNT_LAST) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // One iteration shifts {adjusted scratch, binary} left by one bit.
  always_comb begin
    accept      = (state == IDLE) && iSTART;
    lastIter    = (state == CONV) && (iterCnt == CNT_LAST);
    scratchNext = {scratchAdj[4*BCD_DIGITS-2:0], binReg[BIN_W-1]};
    binNext     = {binReg[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      binReg  <= '0;
      scratch <= '0;
      iterCnt <= '0;
      ovfFlag <= 1'b0;
      oBCD    <= '0;
      oOVF    <= 1'b0;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      oDONE <= lastIter;
      if (accept) begin
        binReg  <= iBIN;
        scratch <= '0;
        iterCnt <= '0;
        ovfFlag <= (iBIN > BIN_W'(MAX_BCD_VAL));
        oBUSY   <= 1'b1;
      end else if (state == CONV) begin
        binReg  <= binNext;
        scratch <= scratchNext;
        iterCnt <= iterCnt + 1'b1;
        if (lastIter) begin
          oBCD  <= ovfFlag ? OVF_CODE : scratchNext;
          oOVF  <= ovfFlag;
          oBUSY <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_4.sv
// Bench for bin_to_bcd_4: cycle model built from decimal arithmetic, checked every cycle,
// plus directed scenarios with literal expectations and a randomized value sweep.
module tb_bin_to_bcd_4;

  localparam logic [15:0] OVF = 16'h9999;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic [15:0] iBIN = 16'd0;
  logic [15:0] oBCD;
  logic        oBUSY, oDONE, oOVF;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;

  bin_to_bcd_4 #(.OVF_CODE(OVF)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iBIN(iBIN),
    .oBCD(oBCD), .oBUSY(oBUSY), .oDONE(oDONE), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [15:0] toBcd(input int unsigned v);
    logic [15:0] r;
    if (v > 9999) return OVF;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a conversion occupies 16 cycles, then the decimal result appears with a 1-cycle done.
  logic        mValid = 1'b0;
  logic        mBusy = 1'b0, mDone = 1'b0, mOvf = 1'b0;
  logic [15:0] mBcd = 16'h0;
  int unsigned mVal = 0;
  int          mLeft = 0;

  always @(posedge iCLK) begin
    cyc++;
    if (iRST) begin
      mValid = 1'b1; mBusy = 1'b0; mDone = 1'b0; mOvf = 1'b0; mBcd = 16'h0; mLeft = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0; mDone = 1'b1;
          mOvf  = (mVal > 9999);
          mBcd  = toBcd(mVal);
        end
      end else if (iSTART) begin
        mBusy = 1'b1; mLeft = 16; mVal = iBIN;
      end
    end
  end

  always @(negedge iCLK) begin
    if (mValid) begin
      check("cyc_busy", 32'(oBUSY), 32'(mBusy));
      check("cyc_done", 32'(oDONE), 32'(mDone));
      check("cyc_ovf",  32'(oOVF),  32'(mOvf));
      check("cyc_bcd",  32'(oBCD),  32'(mBcd));
    end
  end

  // Caller is #1 after a posedge. Returns in the cycle where oDONE is high.
  task automatic convert(input logic [15:0] v, input bit scramble,
                         output int lat, output int busyCnt);
    iBIN = v; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    lat = 0;
    busyCnt = int'(oBUSY);
    while (lat < 40) begin
      if (scramble) iBIN = 16'($urandom);
      @(posedge iCLK); #1;
      lat++;
      if (oDONE) break;
      busyCnt += int'(oBUSY);
    end
    if (!oDONE) check("done_timeout", 32'(lat), 32'd16);
  endtask

  initial begin
    int lat, busyCnt, doneCyc, dones;
    logic [15:0] v;

    check("model_1234", 32'(toBcd(1234)), 32'h1234);
    check("model_9999", 32'(toBcd(9999)), 32'h9999);
    check("model_10000", 32'(toBcd(10000)), 32'h9999);
    check("model_42", 32'(toBcd(42)), 32'h0042);

    repeat (3) @(posedge iCLK);
    #1;
    check("rst_bcd", 32'(oBCD), 32'h0);
    check("rst_busy", 32'(oBUSY), 32'h0);
    check("rst_done", 32'(oDONE), 32'h0);
    check("rst_ovf", 32'(oOVF), 32'h0);
    iRST = 1'b0;
    @(posedge iCLK); #1;

    convert(16'd1234, 1'b0, lat, busyCnt);
    check("t1234_lat", 32'(lat), 32'd16);
    check("t1234_busy", 32'(busyCnt), 32'd16);
    check("t1234_bcd", 32'(oBCD), 32'h1234);
    check("t1234_ovf", 32'(oOVF), 32'h0);
    @(posedge iCLK); #1;
    check("t1234_pulse", 32'(oDONE), 32'h0);
    check("t1234_hold", 32'(oBCD), 32'h1234);

    convert(16'd0, 1'b0, lat, busyCnt);
    check("t0_bcd", 32'(oBCD), 32'h0000);
    doneCyc = cyc;
    convert(16'd9999, 1'b0, lat, busyCnt);
    check("t9999_gap", 32'(cyc - doneCyc), 32'd17);
    check("t9999_bcd", 32'(oBCD), 32'h9999);
    check("t9999_ovf", 32'(oOVF), 32'h0);

    convert(16'd10000, 1'b0, lat, busyCnt);
    check("t10000_bcd", 32'(oBCD), 32'(OVF));
    check("t10000_ovf", 32'(oOVF), 32'h1);
    convert(16'd65535, 1'b0, lat, busyCnt);
    check("t65535_bcd", 32'(oBCD), 32'(OVF));
    check("t65535_ovf", 32'(oOVF), 32'h1);
    convert(16'd42, 1'b0, lat, busyCnt);
    check("t42_bcd", 32'(oBCD), 32'h0042);
    check("t42_ovf", 32'(oOVF), 32'h0);
    @(posedge iCLK); #1;

    // Restart attempts during a conversion must be ignored.
    iBIN = 16'd500; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      iSTART = (c == 3 || c == 10);
      if (iSTART) iBIN = 16'd777;
      @(posedge iCLK); #1;
      if (oDONE) begin
        dones++;
        check("t500_bcd", 32'(oBCD), 32'h0500);
      end
    end
    iSTART = 1'b0;
    check("t500_dones", 32'(dones), 32'd1);

    // Reset mid-conversion aborts without a result.
    iBIN = 16'd8888; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (8) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    check("abort_busy", 32'(oBUSY), 32'h0);
    check("abort_bcd", 32'(oBCD), 32'h0);
    check("abort_done", 32'(oDONE), 32'h0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge iCLK); #1;
      dones += int'(oDONE);
    end
    check("abort_nodone", 32'(dones), 32'd0);

    iRST = 1'b1; iSTART = 1'b1; iBIN = 16'd321;
    @(posedge iCLK); #1;
    iRST = 1'b0; iSTART = 1'b0;
    check("rst_prio_busy", 32'(oBUSY), 32'h0);
    @(posedge iCLK); #1;
    check("rst_prio_idle", 32'(oBUSY), 32'h0);

    for (int n = 0; n < 60; n++) begin
      v = (n % 2 == 0) ? 16'($urandom_range(9999, 0)) : 16'($urandom);
      convert(v, 1'b1, lat, busyCnt);
      check("rand_lat", 32'(lat), 32'd16);
      check("rand_bcd", 32'(oBCD), 32'(toBcd(int'(v))));
      check("rand_ovf", 32'(oOVF), 32'(v > 16'd9999));
      if (n % 3 == 0) repeat (2) @(posedge iCLK);
      #0;
    end

    repeat (2) @(posedge iCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
